// File: rtl/pla_scan_pkg.sv
// Shared types and helpers for the PLA digit scanner: scan FSM states,
// code width and an index-to-one-hot helper (up to 8 digits).
package pla_scan_pkg;

    localparam int CODE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        GUARD
    } scan_state_t;

    function automatic logic [7:0] one_hot(input logic [2:0] idx);
        logic [7:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/pla_scan_prescaler.sv
// Loadable down-counter shared by the dwell and guard intervals; tc is high
// while the count sits at zero, i.e. on the last cycle of the loaded interval.
module pla_scan_prescaler #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             tc
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - WIDTH'(1);
        end
    end

    assign tc = (count_reg == '0);

endmodule

// File: rtl/pla_digit_scan.sv
// Time-multiplexed digit scanner feeding the 4-in/7-out PLA segment decoder.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading-zero digits.
module pla_digit_scan
    import pla_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DIV_WIDTH    = 16,
    parameter int DWELL_CYCLES = 1000,
    parameter int GUARD_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [$clog2(NUM_DIGITS)-1:0] wr_idx,
    input  logic [3:0]                    wr_data,
    input  logic                          commit,
    output logic [3:0]                    x_out,
    output logic [NUM_DIGITS-1:0]         digit_sel,
    output logic                          frame_tick
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [DIV_WIDTH-1:0] DWELL_LOAD = DIV_WIDTH'(DWELL_CYCLES - 1);
    localparam logic [DIV_WIDTH-1:0] GUARD_LOAD = DIV_WIDTH'(GUARD_CYCLES - 1);
    localparam logic [IDX_W-1:0]     LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

    scan_state_t           state_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic [CODE_W-1:0]     active_reg [NUM_DIGITS];
    logic [CODE_W-1:0]     shadow_reg [NUM_DIGITS];
    logic                  commit_pending_reg;
    logic [CODE_W-1:0]     x_out_reg;
    logic [NUM_DIGITS-1:0] digit_sel_reg;
    logic                  frame_tick_reg;

    logic                  presc_load;
    logic [DIV_WIDTH-1:0]  presc_value;
    logic                  presc_tc;
    logic                  wr_fire;
    logic                  copy_now;
    logic [NUM_DIGITS-1:0] blank;

    pla_scan_prescaler #(.WIDTH(DIV_WIDTH)) u_prescaler (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (presc_load),
        .load_value (presc_value),
        .tc         (presc_tc)
    );

    always_comb begin
        presc_load  = 1'b0;
        presc_value = DWELL_LOAD;
        if (en) begin
            case (state_reg)
                IDLE:    presc_load = 1'b1;
                SHOW: begin
                    if (presc_tc) begin
                        presc_load  = 1'b1;
                        presc_value = GUARD_LOAD;
                    end
                end
                GUARD:   presc_load = presc_tc;
                default: presc_load = 1'b0;
            endcase
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS*CODE_W-1:0] active_flat;
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lzb
        assign active_flat[gi*CODE_W +: CODE_W] = active_reg[gi];
        // A digit is blank when it and every more significant digit are zero.
        if (gi == 0) begin : g_lsd
            assign blank[gi] = 1'b0;
        end else begin : g_upper
            assign blank[gi] = (active_flat[NUM_DIGITS*CODE_W-1:gi*CODE_W] == '0);
        end
    end
`else
    assign blank = '0;
`endif

    // Writes are refused while a commit is pending, so a copy never races a write.
    assign wr_fire  = wr_valid && !commit_pending_reg;
    assign copy_now = commit_pending_reg && (frame_tick_reg || state_reg == IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            commit_pending_reg <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_reg[i] <= '0;
                active_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (wr_fire && wr_idx == IDX_W'(i)) shadow_reg[i] <= wr_data;
                if (copy_now) active_reg[i] <= shadow_reg[i];
            end
            if (copy_now) commit_pending_reg <= 1'b0;
            else if (commit) commit_pending_reg <= 1'b1;
        end
    end

    // Outputs are registered from the current state, so select and code move together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            idx_reg        <= '0;
            digit_sel_reg  <= '0;
            x_out_reg      <= '0;
            frame_tick_reg <= 1'b0;
        end else begin
            digit_sel_reg  <= '0;
            frame_tick_reg <= 1'b0;
            if (!en) begin
                state_reg <= IDLE;
                idx_reg   <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        state_reg <= SHOW;
                        idx_reg   <= '0;
                    end
                    SHOW: begin
                        digit_sel_reg <= blank[idx_reg] ? '0 : NUM_DIGITS'(one_hot(3'(idx_reg)));
                        x_out_reg     <= active_reg[idx_reg];
                        if (presc_tc) begin
                            state_reg      <= GUARD;
                            frame_tick_reg <= (idx_reg == LAST_IDX);
                        end
                    end
                    GUARD: begin
                        if (presc_tc) begin
                            state_reg <= SHOW;
                            idx_reg   <= (idx_reg == LAST_IDX) ? '0 : idx_reg + IDX_W'(1);
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign wr_ready   = !commit_pending_reg;
    assign x_out      = x_out_reg;
    assign digit_sel  = digit_sel_reg;
    assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_pla_digit_scan.sv
// Bench for pla_digit_scan: write-table vectors plus a per-cycle scan scoreboard
// built from the dwell/guard timeline; a 3-digit instance covers out-of-range writes.
module tb_pla_digit_scan;

    localparam int N  = 4;
    localparam int DW = 3;
    localparam int GD = 1;
    localparam int FRAME = N * (DW + GD);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, en, wr_valid, commit, wr_ready, frame_tick;
    logic [1:0] wr_idx;
    logic [3:0] wr_data, x_out, digit_sel;

    logic       en3, wr_valid3, commit3, wr_ready3, frame_tick3;
    logic [1:0] wr_idx3;
    logic [3:0] wr_data3, x_out3;
    logic [2:0] digit_sel3;

    pla_digit_scan #(.NUM_DIGITS(N), .DIV_WIDTH(16), .DWELL_CYCLES(DW), .GUARD_CYCLES(GD)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_idx(wr_idx), .wr_data(wr_data), .commit(commit), .x_out(x_out),
        .digit_sel(digit_sel), .frame_tick(frame_tick)
    );

    pla_digit_scan #(.NUM_DIGITS(3), .DIV_WIDTH(8), .DWELL_CYCLES(2), .GUARD_CYCLES(1)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .en(en3), .wr_valid(wr_valid3), .wr_ready(wr_ready3),
        .wr_idx(wr_idx3), .wr_data(wr_data3), .commit(commit3), .x_out(x_out3),
        .digit_sel(digit_sel3), .frame_tick(frame_tick3)
    );

    typedef struct {
        logic [3:0] sel;
        logic [3:0] x;
        logic       ft;
        logic       rdy;
    } exp_t;

    typedef struct {
        logic [1:0] idx;
        logic [3:0] data;
        logic       rdy;
    } wr_vec_t;

    int         vectors = 0;
    int         miscompares = 0;
    exp_t       exp_q[$];
    logic [3:0] cur[N];
    logic [3:0] shd[N];
    logic [3:0] x_hold;
    logic       pend;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic blank_model(input int d);
`ifdef LEADING_ZERO_BLANK_EN
        if (d == 0) return 1'b0;
        for (int i = d; i < N; i++) if (cur[i] != 4'h0) return 1'b0;
        return 1'b1;
`else
        return (d < 0);
`endif
    endfunction

    // Enables the scan from IDLE and checks nsamp samples; optionally writes
    // idx2=A at sample commit_at and pulses commit one cycle later.
    task automatic run_scan(input int nsamp, input int commit_at);
        exp_t e, got;
        int   j, d, ph;
        en = 1'b1;
        for (int k = 0; k < nsamp; k++) begin
            if (k == 0) begin
                e.sel = 4'h0;
                e.x   = x_hold;
            end else begin
                j  = k - 1;
                d  = (j / (DW + GD)) % N;
                ph = j % (DW + GD);
                if (ph < DW) begin
                    e.x    = cur[d];
                    x_hold = cur[d];
                    e.sel  = blank_model(d) ? 4'h0 : 4'(1 << d);
                end else begin
                    e.sel = 4'h0;
                    e.x   = x_hold;
                end
            end
            e.ft  = ((k % FRAME) == FRAME - 1);
            e.rdy = !pend;
            exp_q.push_back(e);
            step();
            got = exp_q.pop_front();
            check($sformatf("scan_sel[%0d]", k), 32'(digit_sel), 32'(got.sel));
            check($sformatf("scan_x[%0d]", k), 32'(x_out), 32'(got.x));
            check($sformatf("scan_ft[%0d]", k), 32'(frame_tick), 32'(got.ft));
            check($sformatf("scan_rdy[%0d]", k), 32'(wr_ready), 32'(got.rdy));
            if (got.ft) $display("frame boundary at sample %0d", k);
            if (got.ft && pend) begin
                cur  = shd;
                pend = 1'b0;
            end
            wr_valid = 1'b0;
            commit   = 1'b0;
            if (k == commit_at) begin
                wr_valid = 1'b1;
                wr_idx   = 2'd2;
                wr_data  = 4'hA;
                shd[2]   = 4'hA;
            end
            if (k == commit_at + 1) begin
                commit = 1'b1;
                pend   = 1'b1;
            end
        end
    endtask

    initial begin
        wr_vec_t    wv[4];
        wr_vec_t    wv3[4];
        logic [3:0] cur3[3];
        logic [3:0] xh3;
        logic [2:0] esel3;
        logic [3:0] ex3;
        int         j3;

        rst_n = 1'b0; en = 1'b1; wr_valid = 1'b0; commit = 1'b0; wr_idx = '0; wr_data = '0;
        en3 = 1'b0; wr_valid3 = 1'b0; commit3 = 1'b0; wr_idx3 = '0; wr_data3 = '0;
        pend = 1'b0; x_hold = 4'h0;
        for (int i = 0; i < N; i++) begin
            cur[i] = 4'h0;
            shd[i] = 4'h0;
        end

        // Reset held with en=1, then first SHOW two cycles after release.
        repeat (3) step();
        check("rst_sel", 32'(digit_sel), 32'h0);
        check("rst_x", 32'(x_out), 32'h0);
        check("rst_rdy", 32'(wr_ready), 32'h1);
        check("rst_ft", 32'(frame_tick), 32'h0);
        rst_n = 1'b1;
        step();
        check("release_idle_sel", 32'(digit_sel), 32'h0);
        step();
        check("first_show_sel", 32'(digit_sel), 32'h1);
        check("first_show_x", 32'(x_out), 32'h0);
        rst_n = 1'b0;
        en    = 1'b0;
        step();
        check("midop_rst_sel", 32'(digit_sel), 32'h0);
        rst_n = 1'b1;
        step();

        // Load codes 1..4 into the shadow bank, commit from IDLE.
        for (int i = 0; i < N; i++) wv[i] = '{idx: 2'(i), data: 4'(i + 1), rdy: 1'b1};
        for (int i = 0; i < N; i++) begin
            wr_valid = 1'b1;
            wr_idx   = wv[i].idx;
            wr_data  = wv[i].data;
            check($sformatf("wr_rdy[%0d]", i), 32'(wr_ready), 32'(wv[i].rdy));
            $display("write idx=%0d data=%0h", wv[i].idx, wv[i].data);
            step();
            shd[wv[i].idx] = wv[i].data;
        end
        wr_valid = 1'b0;
        commit   = 1'b1;
        step();
        commit = 1'b0;
        check("idle_commit_pending_rdy", 32'(wr_ready), 32'h0);
        step();
        check("idle_commit_done_rdy", 32'(wr_ready), 32'h1);
        cur = shd;

        // Four frames; mid-frame 2 write idx2=A + commit, visible from frame 3.
        run_scan(4 * FRAME, 2 * FRAME + 4);

        en = 1'b0;
        step();
        check("drop_after_frames_sel", 32'(digit_sel), 32'h0);

        // Scan to GUARD of idx1, drop en, then restart at digit 0.
        run_scan(8, -10);
        en = 1'b0;
        step();
        check("drop_guard_sel", 32'(digit_sel), 32'h0);
        check("drop_guard_x", 32'(x_out), 32'(x_hold));
        check("drop_guard_ft", 32'(frame_tick), 32'h0);
        repeat (2) step();
        check("idle_hold_sel", 32'(digit_sel), 32'h0);
        run_scan(10, -10);
        en = 1'b0;
        step();

        // Out-of-range write on a 3-digit instance is accepted and discarded.
        wv3[0] = '{idx: 2'd0, data: 4'h5, rdy: 1'b1};
        wv3[1] = '{idx: 2'd1, data: 4'h6, rdy: 1'b1};
        wv3[2] = '{idx: 2'd2, data: 4'h7, rdy: 1'b1};
        wv3[3] = '{idx: 2'd3, data: 4'hF, rdy: 1'b1};
        cur3[0] = 4'h5; cur3[1] = 4'h6; cur3[2] = 4'h7;
        for (int i = 0; i < 4; i++) begin
            wr_valid3 = 1'b1;
            wr_idx3   = wv3[i].idx;
            wr_data3  = wv3[i].data;
            check($sformatf("wr3_rdy[%0d]", i), 32'(wr_ready3), 32'(wv3[i].rdy));
            $display("write3 idx=%0d data=%0h", wv3[i].idx, wv3[i].data);
            step();
        end
        wr_valid3 = 1'b0;
        commit3   = 1'b1;
        step();
        commit3 = 1'b0;
        step();
        check("oor_commit_rdy", 32'(wr_ready3), 32'h1);
        en3 = 1'b1;
        xh3 = 4'h0;
        for (int k = 0; k < 13; k++) begin
            step();
            esel3 = 3'h0;
            ex3   = xh3;
            if (k > 0) begin
                j3 = k - 1;
                if ((j3 % 3) < 2) begin
                    esel3 = 3'(1 << ((j3 / 3) % 3));
                    ex3   = cur3[(j3 / 3) % 3];
                    xh3   = ex3;
                end
            end
            check($sformatf("oor_sel[%0d]", k), 32'(digit_sel3), 32'(esel3));
            check($sformatf("oor_x[%0d]", k), 32'(x_out3), 32'(ex3));
            check($sformatf("oor_ft[%0d]", k), 32'(frame_tick3), 32'((k % 9) == 8));
        end
        en3 = 1'b0;

        // Codes {0,0,7,0} (idx3..0); last write shares its cycle with commit.
        wv[0] = '{idx: 2'd0, data: 4'h0, rdy: 1'b1};
        wv[1] = '{idx: 2'd1, data: 4'h7, rdy: 1'b1};
        wv[2] = '{idx: 2'd2, data: 4'h0, rdy: 1'b1};
        wv[3] = '{idx: 2'd3, data: 4'h0, rdy: 1'b1};
        for (int i = 0; i < N; i++) begin
            wr_valid = 1'b1;
            wr_idx   = wv[i].idx;
            wr_data  = wv[i].data;
            commit   = (i == N - 1);
            check($sformatf("lz_wr_rdy[%0d]", i), 32'(wr_ready), 32'(wv[i].rdy));
            $display("write idx=%0d data=%0h", wv[i].idx, wv[i].data);
            step();
            shd[wv[i].idx] = wv[i].data;
        end
        wr_valid = 1'b0;
        commit   = 1'b0;
        check("same_cycle_commit_rdy", 32'(wr_ready), 32'h0);
        step();
        check("same_cycle_commit_done_rdy", 32'(wr_ready), 32'h1);
        cur = shd;
        run_scan(FRAME + 1, -10);
        en = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
